// File: rtl/act_lut_arbiter.sv
// Round-robin front end for the shared activation ROM: picks one MAC sum per cycle,
// scales/saturates it into a ROM address and routes the looked-up byte back 2 edges later.
module act_lut_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ACC_WIDTH = 20,
  parameter int SHIFT     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ACC_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [10:0]                    rom_addr,
  input  logic [7:0]                     rom_q,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [7:0]                     rsp_data,
  output logic [15:0]                    sat_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t SatHi = acc_t'(1023);
  localparam acc_t SatLo = acc_t'(-1024);
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [10:0]        rom_addr_q, rom_addr_d;
  logic               s1_valid_q, s2_valid_q;
  logic [IW-1:0]      s1_idx_q, s2_idx_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic [15:0]        sat_q;

  logic               gnt_any;
  logic [IW-1:0]      gnt_idx;
  logic               accept;
  acc_t               req_arr [NUM_REQ];
  acc_t               shifted;
  logic               sat_hi, sat_lo;
  logic [10:0]        clipped;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arr[i] = acc_t'(req_data[i*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Search from the pointer, wrapping, so the most recently served requester goes last.
  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept    = gnt_any & rst_n;
  assign req_ready = accept ? (OneHot0 << gnt_idx) : '0;
  assign ptr_d     = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Offset-binary address: flipping the sign bit of the clipped value adds 1024.
  always_comb begin
    shifted    = req_arr[gnt_idx] >>> SHIFT;
    sat_hi     = shifted > SatHi;
    sat_lo     = shifted < SatLo;
    clipped    = sat_hi ? 11'h3FF : (sat_lo ? 11'h400 : shifted[10:0]);
    rom_addr_d = {~clipped[10], clipped[9:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rom_addr_q  <= 11'h400;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      sat_q       <= '0;
    end else begin
      if (accept) begin
        ptr_q      <= ptr_d;
        rom_addr_q <= rom_addr_d;
        if ((sat_hi || sat_lo) && (sat_q != 16'hFFFF)) begin
          sat_q <= sat_q + 16'd1;
        end
      end
      s1_valid_q  <= accept;
      s1_idx_q    <= gnt_idx;
      s2_valid_q  <= s1_valid_q;
      s2_idx_q    <= s1_idx_q;
      rsp_valid_q <= s2_valid_q ? (OneHot0 << s2_idx_q) : '0;
      if (s2_valid_q) begin
        rsp_data_q <= rom_q;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_act_lut_arbiter.sv
// Randomized bench for act_lut_arbiter: a cycle-level model (queue of expected
// responses, floor-division scaling) predicts grants, addresses, responses and sat_count.
module tb_act_lut_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic [10:0]       rom_addr;
  logic [7:0]        rom_q;
  logic [N-1:0]      rsp_valid;
  logic [7:0]        rsp_data;
  logic [15:0]       sat_count;

  act_lut_arbiter #(.NUM_REQ(N), .ACC_WIDTH(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rom_addr(rom_addr), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [2048];
  always @(posedge clk) rom_q <= rom[rom_addr];

  typedef struct { int due; int idx; int addr; } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mPtr = 0;
  int          mSat = 0;
  logic [10:0] mAddr = 11'h400;
  logic [7:0]  mRspData = 8'h00;
  rsp_t        mQ[$];
  int          lastGrant = -1;

  logic [N-1:0]  drvValid = '0;
  logic [AW-1:0] drvData [N];

  logic [N-1:0]  obsReady, expReady, obsRspValid, expRspValid;
  logic [10:0]   obsAddr;
  logic [7:0]    obsRspData;
  logic [15:0]   obsSat;

  function automatic int modelAddr(input logic [AW-1:0] d, output bit sat);
    int v, s;
    v = int'($signed(d));
    if (v >= 0) s = v / (1 << SH);
    else        s = -((-v + (1 << SH) - 1) / (1 << SH));
    sat = 1'b0;
    if (s > 1023) begin s = 1023; sat = 1'b1; end
    else if (s < -1024) begin s = -1024; sat = 1'b1; end
    return s + 1024;
  endfunction

  // Drives one cycle from drvValid/drvData and advances the reference model.
  task automatic drive_cycle();
    int g, a;
    bit sat;
    rsp_t r;
    for (int i = 0; i < N; i++) req_data[i*AW +: AW] = drvData[i];
    req_valid = drvValid;
    #1;
    obsReady = req_ready;
    g = -1;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && drvValid[(mPtr + i) % N]) g = (mPtr + i) % N;
      end
    end
    expReady = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    @(posedge clk);
    cyc++;
    lastGrant = g;
    if (g >= 0) begin
      mPtr = (g + 1) % N;
      a = modelAddr(drvData[g], sat);
      mAddr = 11'(a);
      if (sat && mSat < 65535) mSat++;
      mQ.push_back('{due: cyc + 2, idx: g, addr: a});
    end
    @(negedge clk);
    obsAddr = rom_addr;
    obsRspValid = rsp_valid;
    obsRspData = rsp_data;
    obsSat = sat_count;
    expRspValid = '0;
    if (mQ.size() > 0 && mQ[0].due == cyc) begin
      r = mQ.pop_front();
      expRspValid = 4'b0001 << r.idx;
      mRspData = rom[r.addr];
    end
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (rom_addr !== 11'h400) begin errors++; $display("[TB] FAIL reset_addr got %h want 400", rom_addr); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp_data got %h want 00", rsp_data); end
    checks++; if (sat_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sat got %h want 0000", sat_count); end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drvValid = 4'b0001;
    drvData[0] = '0;
    drive_cycle();
    checks++; if (obsReady !== 4'b0001) begin errors++; $display("[TB] FAIL basic_ready got %b want 0001", obsReady); end
    checks++; if (obsAddr !== 11'h400) begin errors++; $display("[TB] FAIL basic_addr got %h want 400", obsAddr); end
    drvValid = '0;
    drive_cycle();
    checks++; if (obsRspValid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_early_rsp got %b want 0000", obsRspValid); end
    drive_cycle();
    checks++; if (obsRspValid !== 4'b0001) begin errors++; $display("[TB] FAIL basic_rsp_valid got %b want 0001", obsRspValid); end
    checks++; if (obsRspData !== rom[11'h400]) begin errors++; $display("[TB] FAIL basic_rsp_data got %h want %h", obsRspData, rom[11'h400]); end
    checks++; if (obsSat !== 16'd0) begin errors++; $display("[TB] FAIL basic_sat got %0d want 0", obsSat); end
  endtask

  task automatic test_scaling();
    logic [AW-1:0] vals [4];
    logic [10:0]   addrs [4];
    vals  = '{20'h00100, 20'hFFFF0, 20'h7FFFF, 20'h80000};
    addrs = '{11'h410, 11'h3FF, 11'h7FF, 11'h000};
    drvValid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      drvData[1] = vals[i];
      drive_cycle();
      checks++; if (obsReady !== 4'b0010) begin errors++; $display("[TB] FAIL scale_ready[%0d] got %b want 0010", i, obsReady); end
      checks++; if (obsAddr !== addrs[i]) begin errors++; $display("[TB] FAIL scale_addr[%0d] got %h want %h", i, obsAddr, addrs[i]); end
      checks++; if (obsAddr !== mAddr) begin errors++; $display("[TB] FAIL scale_model_addr[%0d] got %h want %h", i, obsAddr, mAddr); end
    end
    drvValid = '0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      checks++; if (obsRspValid !== expRspValid) begin errors++; $display("[TB] FAIL scale_rsp_valid got %b want %b", obsRspValid, expRspValid); end
      checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL scale_rsp_data got %h want %h", obsRspData, mRspData); end
    end
    checks++; if (obsSat !== 16'd2) begin errors++; $display("[TB] FAIL scale_sat got %0d want 2", obsSat); end
  endtask

  task automatic test_round_robin();
    drvValid = 4'b1000;
    drvData[3] = AW'($urandom);
    drive_cycle();
    drvValid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) drvData[j] = AW'($urandom);
      drive_cycle();
      checks++; if (obsReady !== (4'b0001 << (i % 4))) begin errors++; $display("[TB] FAIL rr_grant[%0d] got %b want %b", i, obsReady, 4'b0001 << (i % 4)); end
      checks++; if (obsRspValid !== expRspValid) begin errors++; $display("[TB] FAIL rr_rsp_valid[%0d] got %b want %b", i, obsRspValid, expRspValid); end
      checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL rr_rsp_data[%0d] got %h want %h", i, obsRspData, mRspData); end
      if (i >= 2) begin
        checks++; if (obsRspValid !== (4'b0001 << ((i - 2) % 4))) begin errors++; $display("[TB] FAIL rr_rsp_order[%0d] got %b want %b", i, obsRspValid, 4'b0001 << ((i - 2) % 4)); end
      end
    end
    drvValid = '0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      checks++; if (obsRspValid !== expRspValid) begin errors++; $display("[TB] FAIL rr_drain_valid got %b want %b", obsRspValid, expRspValid); end
      checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL rr_drain_data got %h want %h", obsRspData, mRspData); end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] pattern [4];
    logic [N-1:0] want [4];
    pattern = '{4'b0100, 4'b1100, 4'b0100, 4'b1000};
    want    = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drvValid = pattern[i];
      for (int j = 0; j < N; j++) drvData[j] = AW'($urandom);
      drive_cycle();
      checks++; if (obsReady !== want[i]) begin errors++; $display("[TB] FAIL fair_grant[%0d] got %b want %b", i, obsReady, want[i]); end
    end
    drvValid = 4'b0100;
    drive_cycle();
    checks++; if (obsReady !== 4'b0100) begin errors++; $display("[TB] FAIL fair_ptr0_grant got %b want 0100", obsReady); end
    drvValid = '0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      checks++; if (obsRspValid !== expRspValid) begin errors++; $display("[TB] FAIL fair_rsp_valid got %b want %b", obsRspValid, expRspValid); end
      checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL fair_rsp_data got %h want %h", obsRspData, mRspData); end
    end
  endtask

  task automatic test_random();
    drvValid = '0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!drvValid[j] && $urandom_range(0, 2) == 0) begin
          drvValid[j] = 1'b1;
          if ($urandom_range(0, 1) == 0) drvData[j] = AW'($urandom);
          else drvData[j] = AW'(int'($urandom_range(0, 32767)) - 16384);
        end else if (drvValid[j] && $urandom_range(0, 19) == 0) begin
          drvValid[j] = 1'b0;
        end
      end
      drive_cycle();
      if (lastGrant >= 0) drvValid[lastGrant] = 1'b0;
      checks++; if (obsReady !== expReady) begin errors++; $display("[TB] FAIL rand_grant[%0d] got %b want %b", i, obsReady, expReady); end
      checks++; if (obsAddr !== mAddr) begin errors++; $display("[TB] FAIL rand_addr[%0d] got %h want %h", i, obsAddr, mAddr); end
      checks++; if (obsRspValid !== expRspValid) begin errors++; $display("[TB] FAIL rand_rsp_valid[%0d] got %b want %b", i, obsRspValid, expRspValid); end
      checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL rand_rsp_data[%0d] got %h want %h", i, obsRspData, mRspData); end
      checks++; if (obsSat !== 16'(mSat)) begin errors++; $display("[TB] FAIL rand_sat[%0d] got %0d want %0d", i, obsSat, mSat); end
    end
    drvValid = '0;
    drive_cycle();
    drive_cycle();
  endtask

  task automatic test_reset_midflight();
    drvValid = 4'hF;
    for (int j = 0; j < N; j++) drvData[j] = AW'($urandom);
    drive_cycle();
    drive_cycle();
    rst_n = 1'b0;
    #1;
    mQ.delete();
    mPtr = 0; mAddr = 11'h400; mRspData = 8'h00; mSat = 0;
    checks++; if (rom_addr !== 11'h400) begin errors++; $display("[TB] FAIL mid_reset_addr got %h want 400", rom_addr); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_ready got %b want 0000", req_ready); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_sat got %0d want 0", sat_count); end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_rsp got %b want 0000", rsp_valid); end
    rst_n = 1'b1;
    drive_cycle();
    checks++; if (obsReady !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_grant got %b want 0001", obsReady); end
    checks++; if (obsRspValid !== 4'b0000) begin errors++; $display("[TB] FAIL post_reset_stale0 got %b want 0000", obsRspValid); end
    drvValid = '0;
    drive_cycle();
    checks++; if (obsRspValid !== 4'b0000) begin errors++; $display("[TB] FAIL post_reset_stale1 got %b want 0000", obsRspValid); end
    drive_cycle();
    checks++; if (obsRspValid !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_rsp got %b want 0001", obsRspValid); end
    checks++; if (obsRspData !== mRspData) begin errors++; $display("[TB] FAIL post_reset_data got %h want %h", obsRspData, mRspData); end
  endtask

  task automatic test_sat_counter();
    bit reached = 1'b0;
    drvValid = 4'hF;
    for (int i = 0; i < 70000 && !reached; i++) begin
      for (int j = 0; j < N; j++) drvData[j] = ((i + j) % 2 == 0) ? 20'h7FFFF : 20'h80000;
      drive_cycle();
      if (mSat == 1000 || mSat == 65534) begin
        checks++; if (obsSat !== 16'(mSat)) begin errors++; $display("[TB] FAIL sat_mid got %0d want %0d", obsSat, mSat); end
      end
      if (mSat == 65535) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL sat_budget got %0d want 65535", mSat); end
    for (int i = 0; i < 6; i++) begin
      drive_cycle();
      checks++; if (obsSat !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_stick[%0d] got %h want ffff", i, obsSat); end
    end
    drvValid = '0;
    drive_cycle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    for (int j = 0; j < N; j++) drvData[j] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_scaling();
    test_round_robin();
    test_fairness();
    test_random();
    test_reset_midflight();
    test_sat_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_lut_arbiter.md
Name: act_lut_arbiter

Overview:
Shares the single activation-function lookup ROM (2048 x 8, 11-bit address, 1-cycle registered read) among NUM_REQ neuron MAC units. Each requester offers a signed accumulator sum. The block round-robin arbitrates, scales and saturates the sum to an 11-bit ROM address, drives the ROM, and returns the 8-bit activation to the granted requester after fixed latency. It sits between the MAC array and the ROM and owns the ROM address bus exclusively.

Parameters:
NUM_REQ, 4, number of requesting MAC units (2..8)
ACC_WIDTH, 20, width of signed accumulator sum per requester
SHIFT, 4, arithmetic right shift applied to the sum before saturation (0..ACC_WIDTH-11)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*ACC_WIDTH  signed sums; requester i at bits [i*ACC_WIDTH +: ACC_WIDTH]
req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
rom_addr  output  11  registered address to ROM addr
rom_q  input  8  ROM data (q), valid one cycle after rom_addr is presented
rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking rsp_data for requester i
rsp_data  output  8  activation value
sat_count  output  16  count of saturated lookups since reset

Behaviour:
- Reset (async, rst_n=0): RR pointer=0; rom_addr=11'h400 (zero input); all pipeline tags cleared; rsp_valid=0; rsp_data=0; sat_count=0. req_ready is combinational and is 0 while rst_n=0.
- Arbitration: combinational. Search req_valid starting at pointer, wrapping modulo NUM_REQ. The first set bit gets req_ready. At most one grant per cycle; no grant when req_valid=0.
- Pointer update: on accept of requester g, pointer <= (g+1) mod NUM_REQ. Pointer holds when idle.
- Requesters must hold req_valid/req_data stable until accepted. Deasserting req_valid before accept is permitted; that requester simply loses the slot.
- Address formation on accept: s = req_data[g] >>> SHIFT (sign-preserving).
  - s > 1023: clip to 1023 and flag saturated.
  - s < -1024: clip to -1024 and flag saturated.
  - rom_addr <= clipped + 1024 (equivalently, invert the sign bit of the 11-bit clipped value). Address 0 = most negative input; 0x7FF = most positive.
- Pipeline, accept at edge k:
  - edge k: rom_addr loaded; stage-1 tag = {valid, g} loaded.
  - edge k+1: ROM registers q; stage-2 tag loaded from stage-1.
  - edge k+2: rsp_data <= rom_q; rsp_valid <= onehot(g) for exactly one cycle.
  - Fixed latency of 2 edges after accept. Full throughput: one accept per cycle, responses in accept order.
- rom_addr holds its last value when no accept occurs. Idle cycles produce no response.
- rsp_data holds its last value when rsp_valid=0.
- No response backpressure. Requesters must be able to sink a response every cycle.
- sat_count increments by 1 per accepted saturated request and sticks at 16'hFFFF (no wrap).
- Reset mid-operation: in-flight lookups are discarded, no rsp_valid is emitted for them, and the pointer returns to 0.

Test Plan:
- Reset, then req 0 with data 0 -> rom_addr=0x400 after accept edge; rsp_valid=4'b0001 exactly 2 edges after accept, with rsp_data equal to ROM[0x400]; sat_count=0.
- Scaling and saturation on req 1:
  - 20'h00100 -> addr 0x410.
  - 20'hFFFF0 -> addr 0x3FF.
  - 20'h7FFFF -> addr 0x7FF.
  - 20'h80000 -> addr 0x000.
  - Expect sat_count=2 after the sequence.
- All four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle; rsp_valid order matches with 2-cycle lag; no gaps.
- Fairness check:
  - req 2 and req 3 valid with pointer=3 -> grant 3, then 2.
  - Then only req 2 valid with pointer=0 -> grant 2 immediately.
- Assert rst_n=0 for one cycle with two lookups in flight -> no rsp_valid for them; rom_addr=0x400; pointer=0; next accept proceeds normally.
- Force 65536 saturating requests -> sat_count reaches 16'hFFFF and stays there on further saturated lookups.
